uncached_axi_bridge: RTL and testbench

Parametrised N-channel bridge that turns SRAM-like uncached requests into single-beat AXI3 transactions. It supports overlapped reads from different channels (routed by AXI ID), round-robin arbitration, and read-after-write hazard blocking. It sits between the CPU-side request ports and the top-level AXI master interface. It is the generalised successor to the fixed two-port instruction/data SRAM-to-AXI path.

---
 rtl/uncached_axi_bridge.sv | 205 ++++++++++++++++++++
 tb/tb_uncached_axi_bridge.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uncached_axi_bridge.sv
// N-channel SRAM-like to single-beat AXI3 bridge.
// Round-robin grant, ID-routed overlapped reads, RAW blocking.
module uncached_axi_bridge #(
  parameter int NUM_CH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     req,
  input  logic [NUM_CH-1:0]     wr,
  input  logic [2*NUM_CH-1:0]   size,
  input  logic [4*NUM_CH-1:0]   wstrb,
  input  logic [32*NUM_CH-1:0]  addr,
  input  logic [32*NUM_CH-1:0]  wdata,
  output logic [NUM_CH-1:0]     addr_ok,
  output logic [NUM_CH-1:0]     data_ok,
  output logic [32*NUM_CH-1:0]  rdata,
  output logic                  bus_err,
  output logic [3:0]            arid,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [31:0]           axi_rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [3:0]            awid,
  output logic [31:0]           awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [3:0]            wid,
  output logic [31:0]           axi_wdata,
  output logic [3:0]            axi_wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [3:0]            bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  logic [NUM_CH-1:0] busy, ch_wr, raw;
  logic [NUM_CH-1:0] elig, gnt_oh;
  logic [NUM_CH-1:0] r_hit, b_hit;
  logic [3:0]        ptr, gnt_id;
  logic              gnt, hi;
  logic              wif;
  logic [29:0]       wif_addr;
  logic              r_bad, b_bad;
  logic              sel_wr;
  logic [1:0]        sel_size;
  logic [3:0]        sel_wstrb;
  logic [31:0]       sel_addr, sel_wdata;

  assign arlen   = 8'd0;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awlen   = 8'd0;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = awid;
  assign rready  = 1'b1;
  assign bready  = 1'b1;
  assign addr_ok = gnt_oh;
  assign gnt     = |gnt_oh;

  always_comb begin
    raw  = '0;
    elig = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      raw[k]  = wif && (wif_addr == addr[k*32+2 +: 30]);
      elig[k] = req[k] & ~busy[k] &
                (wr[k] ? ~wif : (~arvalid & ~raw[k]));
    end
  end

  // first pass: above ptr; second pass wraps around
  always_comb begin
    gnt_oh = '0;
    gnt_id = '0;
    hi     = 1'b0;
    for (int k = NUM_CH-1; k >= 0; k--) begin
      if (elig[k] && 4'(k) > ptr) begin
        gnt_oh    = '0;
        gnt_oh[k] = 1'b1;
        gnt_id    = 4'(k);
        hi        = 1'b1;
      end
    end
    if (!hi) begin
      for (int k = NUM_CH-1; k >= 0; k--) begin
        if (elig[k]) begin
          gnt_oh    = '0;
          gnt_oh[k] = 1'b1;
          gnt_id    = 4'(k);
        end
      end
    end
  end

  always_comb begin
    sel_wr    = 1'b0;
    sel_size  = '0;
    sel_wstrb = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (gnt_oh[k]) begin
        sel_wr    = wr[k];
        sel_size  = size[k*2 +: 2];
        sel_wstrb = wstrb[k*4 +: 4];
        sel_addr  = addr[k*32 +: 32];
        sel_wdata = wdata[k*32 +: 32];
      end
    end
  end

  always_comb begin
    r_hit = '0;
    b_hit = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      r_hit[k] = rvalid && rid == 4'(k) && busy[k] && !ch_wr[k];
      b_hit[k] = bvalid && bid == 4'(k) && busy[k] && ch_wr[k];
    end
    r_bad = rvalid && (~|r_hit || rresp != 2'b00 || !rlast);
    b_bad = bvalid && (~|b_hit || bresp != 2'b00);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= '0;
      ch_wr     <= '0;
      ptr       <= '0;
      data_ok   <= '0;
      rdata     <= '0;
      bus_err   <= 1'b0;
      wif       <= 1'b0;
      wif_addr  <= '0;
      arvalid   <= 1'b0;
      arid      <= '0;
      araddr    <= '0;
      arsize    <= '0;
      arburst   <= '0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      awid      <= '0;
      awaddr    <= '0;
      awsize    <= '0;
      awburst   <= '0;
      axi_wdata <= '0;
      axi_wstrb <= '0;
      wlast     <= 1'b0;
    end else begin
      busy    <= (busy & ~(r_hit | b_hit)) | gnt_oh;
      data_ok <= r_hit | b_hit;
      bus_err <= bus_err | r_bad | b_bad;
      for (int k = 0; k < NUM_CH; k++)
        if (r_hit[k]) rdata[k*32 +: 32] <= axi_rdata;
      if (arvalid && arready) arvalid <= 1'b0;
      if (awvalid && awready) awvalid <= 1'b0;
      if (wvalid && wready)   wvalid  <= 1'b0;
      if (|b_hit) wif <= 1'b0;
      if (gnt) begin
        ptr   <= gnt_id;
        ch_wr <= (ch_wr & ~gnt_oh) | (gnt_oh & {NUM_CH{sel_wr}});
        if (sel_wr) begin
          awvalid   <= 1'b1;
          wvalid    <= 1'b1;
          awid      <= gnt_id;
          awaddr    <= sel_addr;
          awsize    <= {1'b0, sel_size};
          awburst   <= 2'b01;
          axi_wdata <= sel_wdata;
          axi_wstrb <= sel_wstrb;
          wlast     <= 1'b1;
          wif       <= 1'b1;
          wif_addr  <= sel_addr[31:2];
        end else begin
          arvalid <= 1'b1;
          arid    <= gnt_id;
          araddr  <= sel_addr;
          arsize  <= {1'b0, sel_size};
          arburst <= 2'b01;
        end
      end
    end
  end

endmodule

// File: tb/tb_uncached_axi_bridge.sv
// Directed bench for uncached_axi_bridge with NUM_CH=4.
// Bench plays the AXI slave by hand, one cycle at a time.
module tb_uncached_axi_bridge;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req, wr;
  logic [2*N-1:0] size;
  logic [4*N-1:0] wstrb;
  logic [32*N-1:0] addr, wdata;
  logic [N-1:0]   addr_ok, data_ok;
  logic [32*N-1:0] rdata;
  logic           bus_err;
  logic [3:0]     arid, awid, wid, rid, bid;
  logic [31:0]    araddr, awaddr, axi_rdata, axi_wdata;
  logic [7:0]     arlen, awlen;
  logic [2:0]     arsize, awsize, arprot, awprot;
  logic [1:0]     arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]     arcache, awcache, axi_wstrb;
  logic           arvalid, arready, awvalid, awready;
  logic           rlast, rvalid, rready;
  logic           wlast, wvalid, wready;
  logic           bvalid, bready;

  int checks = 0;
  int failures = 0;

  uncached_axi_bridge #(.NUM_CH(N)) dut (
    .clk(clk), .reset(reset),
    .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .bus_err(bus_err),
    .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .axi_rdata(axi_rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drv(input int k, input logic w,
                     input logic [1:0] s, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] st);
    req[k] = 1'b1;
    wr[k] = w;
    size[k*2 +: 2] = s;
    addr[k*32 +: 32] = a;
    wdata[k*32 +: 32] = d;
    wstrb[k*4 +: 4] = st;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req = '0; wr = '0; size = '0; wstrb = '0;
    addr = '0; wdata = '0;
    arready = 0; awready = 0; wready = 0;
    rid = 0; axi_rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    bid = 0; bresp = 0; bvalid = 0;

    smp();
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_addr_ok", addr_ok, 0);
    chk("rst_data_ok", data_ok, 0);
    chk("rst_rdata", rdata[63:0], 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_rready", rready, 1);
    chk("rst_bready", bready, 1);

    // single read
    nxt(); reset = 1'b0;
    drv(0, 0, 2'd2, 32'h1FC0_0004, 0, 0);
    smp(); chk("t1_addr_ok", addr_ok, 4'b0001);
    nxt(); req = '0; arready = 1;
    smp();
    chk("t1_arvalid", arvalid, 1);
    chk("t1_arid", arid, 0);
    chk("t1_arsize", arsize, 2);
    chk("t1_araddr", araddr, 32'h1FC0_0004);
    chk("t1_arburst", arburst, 1);
    nxt(); arready = 0;
    rvalid = 1; rid = 0; axi_rdata = 32'hDEAD_BEEF;
    smp();
    chk("t1_ar_drop", arvalid, 0);
    chk("t1_no_early", data_ok, 0);
    nxt(); rvalid = 0;
    smp();
    chk("t1_data_ok", data_ok, 4'b0001);
    chk("t1_rdata", rdata[31:0], 32'hDEAD_BEEF);
    nxt(); smp();
    chk("t1_pulse", data_ok, 0);
    chk("t1_bus_err", bus_err, 0);

    // overlapped reads, ptr=0 so ch1 wins first
    nxt();
    drv(0, 0, 2'd2, 32'h0000_0100, 0, 0);
    drv(1, 0, 2'd2, 32'h0000_0200, 0, 0);
    smp(); chk("t2_gnt1", addr_ok, 4'b0010);
    nxt(); req[1] = 0; arready = 1;
    smp();
    chk("t2_slot_full", addr_ok, 0);
    chk("t2_arid1", arid, 1);
    chk("t2_araddr1", araddr, 32'h0000_0200);
    nxt(); smp();
    chk("t2_gnt0", addr_ok, 4'b0001);
    nxt(); req = '0;
    smp();
    chk("t2_arvalid0", arvalid, 1);
    chk("t2_arid0", arid, 0);
    nxt(); arready = 0;
    rvalid = 1; rid = 0; axi_rdata = 32'h1111_1111;
    nxt(); rid = 1; axi_rdata = 32'h2222_2222;
    smp();
    chk("t2_dok0", data_ok, 4'b0001);
    chk("t2_rdata0", rdata[31:0], 32'h1111_1111);
    nxt(); rvalid = 0;
    smp();
    chk("t2_dok1", data_ok, 4'b0010);
    chk("t2_rdata1", rdata[63:32], 32'h2222_2222);

    // RAW block
    nxt(); awready = 1; wready = 1;
    drv(1, 1, 2'd2, 32'h8000_0010, 32'hCAFE_F00D, 4'hF);
    smp(); chk("t3_wgnt", addr_ok, 4'b0010);
    nxt(); req[1] = 0;
    drv(0, 0, 2'd1, 32'h8000_0012, 0, 0);
    smp();
    chk("t3_awvalid", awvalid, 1);
    chk("t3_wvalid", wvalid, 1);
    chk("t3_raw_c1", addr_ok, 0);
    nxt(); smp();
    chk("t3_aw_drop", awvalid, 0);
    chk("t3_raw_c2", addr_ok, 0);
    nxt(); smp();
    chk("t3_raw_c3", addr_ok, 0);
    nxt(); bvalid = 1; bid = 1;
    smp();
    chk("t3_raw_cN", addr_ok, 0);
    nxt(); bvalid = 0;
    smp();
    chk("t3_wdok", data_ok, 4'b0010);
    chk("t3_rgnt", addr_ok, 4'b0001);
    nxt(); req = '0; arready = 1;
    smp();
    chk("t3_araddr", araddr, 32'h8000_0012);
    chk("t3_arsize", arsize, 1);
    nxt(); arready = 0;
    rvalid = 1; rid = 0; axi_rdata = 32'h0000_5A5A;
    nxt(); rvalid = 0;
    smp();
    chk("t3_rdok", data_ok, 4'b0001);
    chk("t3_rdata", rdata[31:0], 32'h0000_5A5A);
    chk("t3_bus_err", bus_err, 0);

    // write channel skew
    nxt(); awready = 0; wready = 1;
    drv(2, 1, 2'd1, 32'h0000_0040, 32'h1234_5678, 4'b0110);
    smp(); chk("t4_gnt", addr_ok, 4'b0100);
    nxt(); req = '0;
    smp();
    chk("t4_awvalid", awvalid, 1);
    chk("t4_wvalid", wvalid, 1);
    chk("t4_awid", awid, 2);
    chk("t4_wid", wid, 2);
    chk("t4_wlast", wlast, 1);
    chk("t4_wstrb", axi_wstrb, 4'b0110);
    chk("t4_wdata", axi_wdata, 32'h1234_5678);
    chk("t4_awsize", awsize, 1);
    nxt(); smp();
    chk("t4_w_drop", wvalid, 0);
    chk("t4_aw_hold2", awvalid, 1);
    nxt(); awready = 1;
    smp(); chk("t4_aw_hold3", awvalid, 1);
    nxt(); awready = 0; bvalid = 1; bid = 2;
    smp(); chk("t4_aw_drop", awvalid, 0);
    nxt(); bvalid = 0;
    smp(); chk("t4_dok", data_ok, 4'b0100);

    // error response, ptr=2 so grant wraps to ch2
    nxt();
    drv(2, 0, 2'd2, 32'h0000_0044, 0, 0);
    smp(); chk("t5_wrap_gnt", addr_ok, 4'b0100);
    nxt(); req = '0; arready = 1;
    smp(); chk("t5_arid", arid, 2);
    nxt(); arready = 0;
    rvalid = 1; rid = 2; rresp = 2'b10; axi_rdata = 32'hBAD0_BAD0;
    smp(); chk("t5_err_pre", bus_err, 0);
    nxt(); rvalid = 0; rresp = 0;
    smp();
    chk("t5_dok", data_ok, 4'b0100);
    chk("t5_err", bus_err, 1);
    chk("t5_rdata", rdata[95:64], 32'hBAD0_BAD0);
    nxt(); reset = 1;
    smp(); chk("t5_err_clr", bus_err, 0);
    nxt(); reset = 0; bvalid = 1; bid = 5;
    smp(); chk("t5_stray_pre", bus_err, 0);
    nxt(); bvalid = 0;
    smp();
    chk("t5_stray_err", bus_err, 1);
    chk("t5_stray_dok", data_ok, 0);

    // reset mid-read
    nxt(); reset = 1;
    nxt(); reset = 0;
    drv(1, 0, 2'd2, 32'h0000_0300, 0, 0);
    smp(); chk("t6_gnt", addr_ok, 4'b0010);
    nxt(); req = '0;
    smp(); chk("t6_arvalid", arvalid, 1);
    reset = 1; #1;
    chk("t6_async_ar", arvalid, 0);
    nxt(); reset = 0;
    rvalid = 1; rid = 1; rresp = 0;
    smp(); chk("t6_no_dok", data_ok, 0);
    nxt(); rvalid = 0;
    drv(1, 0, 2'd2, 32'h0000_0300, 0, 0);
    smp();
    chk("t6_late_err", bus_err, 1);
    chk("t6_busy_clr", addr_ok, 4'b0010);
    chk("t6_dok_none", data_ok, 0);
    nxt(); req = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
